// File: rtl/wb_stage_if.sv
// Writeback stage bus: upstream slot inputs and register-file/CSR/forwarding outputs.
// Retire counter read port present when WB_STAGE_RETIRE_CNT_EN is defined.
interface wb_stage_if #(
    parameter int NUM_HART       = 4,
    parameter int REG_WIDTH      = 32,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int CSR_ADDR_WIDTH = 12
);
    localparam int SHIFT_WIDTH = $clog2(REG_WIDTH / 8);

    logic                      in_valid;
    logic                      in_retire;
    logic [NUM_HART-1:0]       in_hart_sel;
    logic                      in_reg_wr_en;
    logic                      in_reg_wr_sel_z;
    logic [1:0]                in_reg_wr_size;
    logic                      in_reg_wr_sign_ext;
    logic [SHIFT_WIDTH-1:0]    in_reg_wr_shift;
    logic [REG_ADDR_WIDTH-1:0] in_reg_wr_addr;
    logic                      in_csr_wr_en;
    logic [CSR_ADDR_WIDTH-1:0] in_csr_wr_addr;
    logic [REG_WIDTH-1:0]      in_lane_x;
    logic [REG_WIDTH-1:0]      in_lane_y;
    logic [REG_WIDTH-1:0]      in_lane_z;

    logic                      reg_wr_en;
    logic [NUM_HART-1:0]       reg_wr_hart_sel;
    logic [REG_ADDR_WIDTH-1:0] reg_wr_addr;
    logic [REG_WIDTH-1:0]      reg_wr_data;
    logic                      csr_wr_en;
    logic [NUM_HART-1:0]       csr_wr_hart_sel;
    logic [CSR_ADDR_WIDTH-1:0] csr_wr_addr;
    logic [REG_WIDTH-1:0]      csr_wr_data;
    logic                      fwd_valid;
    logic [NUM_HART-1:0]       fwd_hart_sel;
    logic [REG_ADDR_WIDTH-1:0] fwd_addr;
    logic [REG_WIDTH-1:0]      fwd_data;

`ifdef WB_STAGE_RETIRE_CNT_EN
    logic [NUM_HART-1:0]       retire_cnt_hart_sel;
    logic [63:0]               retire_cnt;

    modport master (
        output in_valid, in_retire, in_hart_sel,
        output in_reg_wr_en, in_reg_wr_sel_z, in_reg_wr_size,
        output in_reg_wr_sign_ext, in_reg_wr_shift, in_reg_wr_addr,
        output in_csr_wr_en, in_csr_wr_addr,
        output in_lane_x, in_lane_y, in_lane_z,
        output retire_cnt_hart_sel,
        input  reg_wr_en, reg_wr_hart_sel, reg_wr_addr, reg_wr_data,
        input  csr_wr_en, csr_wr_hart_sel, csr_wr_addr, csr_wr_data,
        input  fwd_valid, fwd_hart_sel, fwd_addr, fwd_data,
        input  retire_cnt
    );

    modport slave (
        input  in_valid, in_retire, in_hart_sel,
        input  in_reg_wr_en, in_reg_wr_sel_z, in_reg_wr_size,
        input  in_reg_wr_sign_ext, in_reg_wr_shift, in_reg_wr_addr,
        input  in_csr_wr_en, in_csr_wr_addr,
        input  in_lane_x, in_lane_y, in_lane_z,
        input  retire_cnt_hart_sel,
        output reg_wr_en, reg_wr_hart_sel, reg_wr_addr, reg_wr_data,
        output csr_wr_en, csr_wr_hart_sel, csr_wr_addr, csr_wr_data,
        output fwd_valid, fwd_hart_sel, fwd_addr, fwd_data,
        output retire_cnt
    );
`else
    modport master (
        output in_valid, in_retire, in_hart_sel,
        output in_reg_wr_en, in_reg_wr_sel_z, in_reg_wr_size,
        output in_reg_wr_sign_ext, in_reg_wr_shift, in_reg_wr_addr,
        output in_csr_wr_en, in_csr_wr_addr,
        output in_lane_x, in_lane_y, in_lane_z,
        input  reg_wr_en, reg_wr_hart_sel, reg_wr_addr, reg_wr_data,
        input  csr_wr_en, csr_wr_hart_sel, csr_wr_addr, csr_wr_data,
        input  fwd_valid, fwd_hart_sel, fwd_addr, fwd_data
    );

    modport slave (
        input  in_valid, in_retire, in_hart_sel,
        input  in_reg_wr_en, in_reg_wr_sel_z, in_reg_wr_size,
        input  in_reg_wr_sign_ext, in_reg_wr_shift, in_reg_wr_addr,
        input  in_csr_wr_en, in_csr_wr_addr,
        input  in_lane_x, in_lane_y, in_lane_z,
        output reg_wr_en, reg_wr_hart_sel, reg_wr_addr, reg_wr_data,
        output csr_wr_en, csr_wr_hart_sel, csr_wr_addr, csr_wr_data,
        output fwd_valid, fwd_hart_sel, fwd_addr, fwd_data
    );
`endif

endinterface

// File: rtl/wb_stage.sv
// Writeback stage: registers the memory-stage slot, aligns/extends loads,
// drives RF/CSR writes and forwarding. Option: WB_STAGE_RETIRE_CNT_EN.
module wb_stage #(
    parameter int NUM_HART       = 4,
    parameter int REG_WIDTH      = 32,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int CSR_ADDR_WIDTH = 12
) (
    input  logic       clk,
    input  logic       rst_n,
    wb_stage_if.slave  wb
);
    localparam int SHIFT_WIDTH = $clog2(REG_WIDTH / 8);

    logic [REG_WIDTH-1:0]      w_shifted;
    logic [REG_WIDTH-1:0]      w_load;
    logic [REG_WIDTH-1:0]      w_rd_data;
    logic [1:0]                w_size;
    logic                      w_msb;
    int                        w_nbits;
    logic                      w_reg_wr_en;
    logic                      w_csr_wr_en;

    logic                      r_reg_wr_en;
    logic [NUM_HART-1:0]       r_reg_wr_hart_sel;
    logic [REG_ADDR_WIDTH-1:0] r_reg_wr_addr;
    logic [REG_WIDTH-1:0]      r_reg_wr_data;
    logic                      r_csr_wr_en;
    logic [NUM_HART-1:0]       r_csr_wr_hart_sel;
    logic [CSR_ADDR_WIDTH-1:0] r_csr_wr_addr;
    logic [REG_WIDTH-1:0]      r_csr_wr_data;

    assign w_reg_wr_en = wb.in_valid & wb.in_reg_wr_en
                       & (wb.in_reg_wr_addr != '0);
    assign w_csr_wr_en = wb.in_valid & wb.in_csr_wr_en;

    // Shift load data down, mask to access size, optionally sign-extend, pick rd source.
    always_comb begin
        w_shifted = wb.in_lane_z >> {wb.in_reg_wr_shift, 3'b000};
        w_size    = wb.in_reg_wr_size;
        if (REG_WIDTH == 32 && w_size == 2'd3) begin
            w_size = 2'd2;
        end
        w_nbits = 8;
        case (w_size)
            2'd0:    w_nbits = 8;
            2'd1:    w_nbits = 16;
            2'd2:    w_nbits = 32;
            default: w_nbits = 64;
        endcase
        w_msb = 1'b0;
        for (int i = 0; i < REG_WIDTH; i++) begin
            if (i == w_nbits - 1) begin
                w_msb = w_shifted[i];
            end
        end
        w_msb = w_msb & wb.in_reg_wr_sign_ext;
        w_load = '0;
        for (int i = 0; i < REG_WIDTH; i++) begin
            w_load[i] = (i < w_nbits) ? w_shifted[i] : w_msb;
        end
        w_rd_data = wb.in_reg_wr_sel_z ? w_load : wb.in_lane_x;
    end

    // Output register: one-cycle latency, strobes gated by slot validity.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_reg_wr_en       <= 1'b0;
            r_reg_wr_hart_sel <= '0;
            r_reg_wr_addr     <= '0;
            r_reg_wr_data     <= '0;
            r_csr_wr_en       <= 1'b0;
            r_csr_wr_hart_sel <= '0;
            r_csr_wr_addr     <= '0;
            r_csr_wr_data     <= '0;
        end else begin
            r_reg_wr_en       <= w_reg_wr_en;
            r_reg_wr_hart_sel <= wb.in_hart_sel;
            r_reg_wr_addr     <= wb.in_reg_wr_addr;
            r_reg_wr_data     <= w_rd_data;
            r_csr_wr_en       <= w_csr_wr_en;
            r_csr_wr_hart_sel <= wb.in_hart_sel;
            r_csr_wr_addr     <= wb.in_csr_wr_addr;
            r_csr_wr_data     <= wb.in_lane_y;
        end
    end

    assign wb.reg_wr_en       = r_reg_wr_en;
    assign wb.reg_wr_hart_sel = r_reg_wr_hart_sel;
    assign wb.reg_wr_addr     = r_reg_wr_addr;
    assign wb.reg_wr_data     = r_reg_wr_data;
    assign wb.csr_wr_en       = r_csr_wr_en;
    assign wb.csr_wr_hart_sel = r_csr_wr_hart_sel;
    assign wb.csr_wr_addr     = r_csr_wr_addr;
    assign wb.csr_wr_data     = r_csr_wr_data;
    assign wb.fwd_valid       = r_reg_wr_en;
    assign wb.fwd_hart_sel    = r_reg_wr_hart_sel;
    assign wb.fwd_addr        = r_reg_wr_addr;
    assign wb.fwd_data        = r_reg_wr_data;

`ifdef WB_STAGE_RETIRE_CNT_EN
    localparam logic [CSR_ADDR_WIDTH-1:0] CSR_CNT_LO =
        CSR_ADDR_WIDTH'(12'hB02);
    localparam logic [CSR_ADDR_WIDTH-1:0] CSR_CNT_HI =
        CSR_ADDR_WIDTH'(12'hB82);

    logic [63:0] r_retire_cnt [NUM_HART];
    logic [63:0] w_retire_cnt;
    logic        w_retire;
    logic        w_cnt_lo_wr;
    logic        w_cnt_hi_wr;

    assign w_retire    = wb.in_valid & wb.in_retire;
    assign w_cnt_lo_wr = w_csr_wr_en & (wb.in_csr_wr_addr == CSR_CNT_LO);
    assign w_cnt_hi_wr = w_csr_wr_en & (wb.in_csr_wr_addr == CSR_CNT_HI);

    // Per-hart retire counters; a CSR write to the counter beats the increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int h = 0; h < NUM_HART; h++) begin
                r_retire_cnt[h] <= '0;
            end
        end else begin
            for (int h = 0; h < NUM_HART; h++) begin
                if (wb.in_hart_sel[h]) begin
                    if (w_cnt_lo_wr) begin
                        r_retire_cnt[h][31:0] <= wb.in_lane_y[31:0];
                    end else if (w_cnt_hi_wr) begin
                        r_retire_cnt[h][63:32] <= wb.in_lane_y[31:0];
                    end else if (w_retire) begin
                        r_retire_cnt[h] <= r_retire_cnt[h] + 64'd1;
                    end
                end
            end
        end
    end

    // One-hot read mux of the selected counter.
    always_comb begin
        w_retire_cnt = '0;
        for (int h = 0; h < NUM_HART; h++) begin
            if (wb.retire_cnt_hart_sel[h]) begin
                w_retire_cnt = w_retire_cnt | r_retire_cnt[h];
            end
        end
    end

    assign wb.retire_cnt = w_retire_cnt;
`else
    logic w_unused_retire;
    assign w_unused_retire = wb.in_retire;
`endif

endmodule
